ro_edge_counter: RTL and testbench

RO_EDGE_COUNTER -- requirements
Module: ro_edge_counter

---
 rtl/ro_edge_counter.sv | 149 ++++++++++++++
 tb/tb_ro_edge_counter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_edge_counter.sv
// ----------------------------------------------------------------------------
// ro_edge_counter
//
// Counts rising edges of a free-running ring oscillator inside a window that
// the system clock domain opens and closes with window_en. All logic runs on
// the oscillator itself (count_clk), so there is no second clock. If the
// oscillator stops, every output simply freezes.
//
// The system side samples count_gray, which changes by at most one bit per
// counting edge. It watches done_toggle to learn that a window has closed.
//
// Parameters
//   WIDTH        counter / output width in bits (4..32)
//   SYNC_STAGES  depth of the window_en synchronizer (2..4)
//
// Ports
//   count_clk    in   ring-oscillator output, counting clock (may stop)
//   reset        in   asynchronous, active-high reset
//   window_en    in   count-window request, asynchronous to count_clk
//   count_bin    out  binary edge count, WIDTH bits
//   count_gray   out  registered Gray copy of count_bin, WIDTH bits
//   overflow     out  sticky: count passed 2^WIDTH-1 in the current window
//   busy         out  high while the counter is in COUNT
//   done_toggle  out  inverts once each time a window closes
//
// Configuration macro
//   RO_CNT_SATURATE_EN  defined: count_bin sticks at 2^WIDTH-1 after overflow
//                       undefined: count_bin wraps to 0 and keeps counting
// ----------------------------------------------------------------------------
module ro_edge_counter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             count_clk,
  input  logic             reset,
  input  logic             window_en,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] count_gray,
  output logic             overflow,
  output logic             busy,
  output logic             done_toggle
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_en;
  logic [WIDTH-1:0]       bin_next;
  logic                   overflow_next;
  logic                   done_next;

  // Binary-to-Gray conversion. The Gray register is loaded from the same
  // next-count value as the binary register, so the two never disagree.
  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] value);
    return value ^ (value >> 1);
  endfunction

  // window_en comes from an unrelated clock domain. It passes through a plain
  // shift-register synchronizer on count_clk before anything else looks at it.
  // Only the last stage (sync_en) is used by the control logic.
  always_ff @(posedge count_clk or posedge reset) begin
    if (reset) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], window_en};
    end
  end

  assign sync_en = sync_ff[SYNC_STAGES-1];

  // Next-state and next-output logic.
  // Opening a window (from IDLE or HOLD) restarts the count at zero and
  // clears the sticky overflow flag.
  // While the window stays open, each edge adds one to the count. Reaching
  // the top of the range sets overflow; the count then either sticks or
  // wraps, depending on the build.
  // Closing a window does not count that edge. It parks the result in HOLD
  // and flips done_toggle so the system side can see a window completed.
  always_comb begin
    state_next    = state;
    bin_next      = count_bin;
    overflow_next = overflow;
    done_next     = done_toggle;
    case (state)
      IDLE, HOLD: begin
        if (sync_en) begin
          state_next    = COUNT;
          bin_next      = '0;
          overflow_next = 1'b0;
        end
      end
      COUNT: begin
        if (sync_en) begin
          if (count_bin == MAX_COUNT) begin
            overflow_next = 1'b1;
`ifdef RO_CNT_SATURATE_EN
            bin_next      = MAX_COUNT;
`else
            bin_next      = '0;
`endif
          end else begin
            bin_next = count_bin + ONE;
          end
        end else begin
          state_next = HOLD;
          done_next  = ~done_toggle;
        end
      end
      default: begin
        state_next    = IDLE;
        bin_next      = '0;
        overflow_next = 1'b0;
      end
    endcase
  end

  // State and output registers.
  // busy is registered from the next state, so it equals the COUNT decode of
  // the state register without any combinational path to the output.
  // Reset clears everything at once, without a count_clk edge. A window that
  // is aborted by reset therefore never flips done_toggle.
  always_ff @(posedge count_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count_bin   <= '0;
      count_gray  <= '0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      done_toggle <= 1'b0;
    end else begin
      state       <= state_next;
      count_bin   <= bin_next;
      count_gray  <= to_gray(bin_next);
      overflow    <= overflow_next;
      busy        <= (state_next == COUNT);
      done_toggle <= done_next;
    end
  end

endmodule

// File: tb/tb_ro_edge_counter.sv
// ----------------------------------------------------------------------------
// tb_ro_edge_counter
//
// Drives two counters from one oscillator, one window request and one reset:
//   dut32  WIDTH=32, SYNC_STAGES=2
//   dut8   WIDTH=8,  SYNC_STAGES=3  (exercises overflow)
//
// The reference model works at the window level:
//   - a delay line for the synchronizer
//   - an unbounded edge tally per window
//   - a count of closed windows
// Expected outputs are derived from the tally with plain arithmetic.
//
// Honours RO_CNT_SATURATE_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_ro_edge_counter;

  localparam int ST32 = 2;
  localparam int ST8  = 3;

  logic        count_clk;
  logic        reset;
  logic        window_en;
  logic [31:0] count_bin32;
  logic [31:0] count_gray32;
  logic        overflow32;
  logic        busy32;
  logic        done32;
  logic [7:0]  count_bin8;
  logic [7:0]  count_gray8;
  logic        overflow8;
  logic        busy8;
  logic        done8;

  int errors = 0;
  int checks = 0;

  bit              m_in     [2];
  longint unsigned m_raw    [2];
  int              m_closes [2];
  bit              mq0[$];
  bit              mq1[$];

  ro_edge_counter #(.WIDTH(32), .SYNC_STAGES(ST32)) dut32 (
    .count_clk   (count_clk),
    .reset       (reset),
    .window_en   (window_en),
    .count_bin   (count_bin32),
    .count_gray  (count_gray32),
    .overflow    (overflow32),
    .busy        (busy32),
    .done_toggle (done32)
  );

  ro_edge_counter #(.WIDTH(8), .SYNC_STAGES(ST8)) dut8 (
    .count_clk   (count_clk),
    .reset       (reset),
    .window_en   (window_en),
    .count_bin   (count_bin8),
    .count_gray  (count_gray8),
    .overflow    (overflow8),
    .busy        (busy8),
    .done_toggle (done8)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Empties the model: no window, zero tally, synchronizer delay lines of zeros.
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_in[k]     = 1'b0;
      m_raw[k]    = 0;
      m_closes[k] = 0;
    end
    mq0 = {};
    mq1 = {};
    repeat (ST32) mq0.push_back(1'b0);
    repeat (ST8)  mq1.push_back(1'b0);
  endtask

  // Advances the model by one oscillator edge. seen is the window request as
  // it emerges from the synchronizer delay line on this edge. inc reports
  // whether this edge was a counting edge inside an open window.
  task automatic model_edge(input int k, input bit en, output bit inc);
    bit seen;
    if (k == 0) begin
      seen = mq0.pop_front();
      mq0.push_back(en);
    end else begin
      seen = mq1.pop_front();
      mq1.push_back(en);
    end
    inc = 1'b0;
    if (seen && m_in[k]) begin
      m_raw[k]++;
      inc = 1'b1;
    end else if (seen) begin
      m_in[k]  = 1'b1;
      m_raw[k] = 0;
    end else if (m_in[k]) begin
      m_in[k] = 1'b0;
      m_closes[k]++;
    end
  endtask

  // Largest count each instance can represent.
  function automatic longint unsigned max_of(input int k);
    return (k == 0) ? 64'hFFFF_FFFF : 64'hFF;
  endfunction

  // Expected binary count, derived from the unbounded tally.
  function automatic longint unsigned exp_bin(input int k);
    if (m_raw[k] <= max_of(k)) return m_raw[k];
`ifdef RO_CNT_SATURATE_EN
    return max_of(k);
`else
    return m_raw[k] % (max_of(k) + 1);
`endif
  endfunction

  function automatic longint unsigned gray_of(input longint unsigned b);
    return b ^ (b >> 1);
  endfunction

  // Compares every output of both instances against the model.
  task automatic checkAll();
    checkOutput("bin32",  {32'b0, count_bin32},  exp_bin(0));
    checkOutput("gray32", {32'b0, count_gray32}, gray_of(exp_bin(0)));
    checkOutput("ovf32",  {63'b0, overflow32},   {63'b0, m_raw[0] > max_of(0)});
    checkOutput("busy32", {63'b0, busy32},       {63'b0, m_in[0]});
    checkOutput("done32", {63'b0, done32},       64'(m_closes[0] % 2));
    checkOutput("bin8",   {56'b0, count_bin8},   exp_bin(1));
    checkOutput("gray8",  {56'b0, count_gray8},  gray_of(exp_bin(1)));
    checkOutput("ovf8",   {63'b0, overflow8},    {63'b0, m_raw[1] > max_of(1)});
    checkOutput("busy8",  {63'b0, busy8},        {63'b0, m_in[1]});
    checkOutput("done8",  {63'b0, done8},        64'(m_closes[1] % 2));
  endtask

  // Runs n oscillator edges with window_en held at en. After each edge it
  // checks all outputs; on counting edges it also checks the Gray step size.
  task automatic applyStimulus(input bit en, input int n);
    logic [31:0] prev32;
    logic [7:0]  prev8;
    bit          inc0;
    bit          inc1;
    for (int i = 0; i < n; i++) begin
      window_en = en;
      prev32    = count_gray32;
      prev8     = count_gray8;
      #5 count_clk = 1'b1;
      #1;
      model_edge(0, en, inc0);
      model_edge(1, en, inc1);
      checkAll();
      if (inc0) checkOutput("gstep32", 64'($countones(prev32 ^ count_gray32) <= 1), 64'd1);
      if (inc1) checkOutput("gstep8",  64'($countones(prev8 ^ count_gray8) <= 1), 64'd1);
      #4 count_clk = 1'b0;
    end
  endtask

  // Pulses reset with the oscillator stopped and checks everything cleared.
  task automatic doReset();
    reset = 1'b1;
    #1;
    model_reset();
    checkAll();
    checkOutput("rst_bin32",  {32'b0, count_bin32}, 64'd0);
    checkOutput("rst_done32", {63'b0, done32},      64'd0);
    #1 reset = 1'b0;
    #1;
  endtask

  initial begin
    int len;
    count_clk = 1'b0;
    window_en = 1'b0;
    reset     = 1'b0;
    model_reset();
    #2;
    doReset();

    // 97 counting edges in dut32: synchronizer sees the request on edges 3..100.
    applyStimulus(1'b1, 98);
    applyStimulus(1'b0, 5);
    checkOutput("r027_bin",  {32'b0, count_bin32}, 64'd97);
    checkOutput("r027_busy", {63'b0, busy32},      64'd0);
    checkOutput("r027_done", {63'b0, done32},      64'd1);

    // Reopen from HOLD: 10 edges in COUNT give a count of 9.
    applyStimulus(1'b1, 12);
    checkOutput("r030_bin",  {32'b0, count_bin32}, 64'd9);
    checkOutput("r030_ovf",  {63'b0, overflow32},  64'd0);
    checkOutput("r030_done", {63'b0, done32},      64'd1);
    applyStimulus(1'b0, 5);
    checkOutput("r030_close", {63'b0, done32},     64'd0);

    // 300 increments in the 8-bit instance.
    doReset();
    applyStimulus(1'b1, 301);
    applyStimulus(1'b0, 5);
`ifdef RO_CNT_SATURATE_EN
    checkOutput("r029_bin8", {56'b0, count_bin8}, 64'd255);
`else
    checkOutput("r029_bin8", {56'b0, count_bin8}, 64'd44);
`endif
    checkOutput("r029_ovf8", {63'b0, overflow8}, 64'd1);

    // Reset mid-COUNT with the clock stopped; no done inversion afterwards.
    applyStimulus(1'b1, 8);
    checkOutput("r031_busy_pre", {63'b0, busy32}, 64'd1);
    doReset();
    checkOutput("r031_busy8", {63'b0, busy8}, 64'd0);
    applyStimulus(1'b0, 6);
    checkOutput("r031_done_after", {63'b0, done32}, 64'd0);

    // One-edge request: a zero-length window at most.
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 6);
    checkOutput("r032_bin32", {32'b0, count_bin32}, 64'd0);
    checkOutput("r032_bin8",  {56'b0, count_bin8},  64'd0);

    // Randomized windows, gaps and occasional resets.
    for (int it = 0; it < 40; it++) begin
      len = (it == 20) ? int'($urandom_range(300, 250)) : int'($urandom_range(40, 1));
      applyStimulus(1'b1, len);
      if ($urandom_range(9, 0) == 0) doReset();
      applyStimulus(1'b0, int'($urandom_range(8, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
